enemy_walker: RTL and testbench

- Consumes the one-hot random_direction produced by the random-direction mux.
- Turns it into tile-by-tile movement of one enemy sprite, one step per frame.
- On a wall/bomb collision it backs off to the tile it started from.
- Outputs the sprite top-left coordinate to the enemy drawing/collision logic.

---
 rtl/enemy_walker.sv | 155 +++++++++++++++
 tb/tb_enemy_walker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/enemy_walker.sv
// Tile-by-tile enemy sprite walker: takes a one-hot direction, steps STEP pixels per
// frame until a full tile is covered, and backs off to the start tile on a collision.
module enemy_walker #(
  parameter int unsigned INIT_X = 64,
  parameter int unsigned INIT_Y = 64,
  parameter int unsigned TILE   = 32,
  parameter int unsigned STEP   = 2,
  parameter int unsigned X_MIN  = 32,
  parameter int unsigned X_MAX  = 576,
  parameter int unsigned Y_MIN  = 32,
  parameter int unsigned Y_MAX  = 416
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        startOfFrame,
  input  logic [3:0]  random_direction,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [3:0]  direction,
  output logic        moving
);

  localparam int unsigned W  = 11;
  localparam int unsigned CW = 12;

  typedef enum logic [1:0] {S_CHOOSE, S_MOVE, S_BACKOFF} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic [W-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic [W-1:0]   prog_q, prog_d;
  logic [3:0]     dir_q, dir_d;
  logic           pend_q, pend_d;
  logic           moving_q, moving_d;

  logic           frame;
  logic           one_hot;
  logic           fits;
  logic [W-1:0]   x_fwd, y_fwd, x_back, y_back;

  assign frame   = enable & startOfFrame;
  assign one_hot = (random_direction != 4'd0) &&
                   ((random_direction & (random_direction - 4'd1)) == 4'd0);

  // Target tile must stay inside the legal box; checked in 12 bits so nothing wraps
  always_comb begin
    fits = 1'b0;
    unique case (random_direction)
      4'b0001: fits = {1'b0, y_q} >= CW'(Y_MIN + TILE);
      4'b0010: fits = ({1'b0, y_q} + CW'(TILE)) <= CW'(Y_MAX);
      4'b0100: fits = {1'b0, x_q} >= CW'(X_MIN + TILE);
      4'b1000: fits = ({1'b0, x_q} + CW'(TILE)) <= CW'(X_MAX);
      default: fits = 1'b0;
    endcase
  end

  // Forward and reverse single-step positions for the latched direction
  always_comb begin
    x_fwd  = x_q;
    y_fwd  = y_q;
    x_back = x_q;
    y_back = y_q;
    unique case (dir_q)
      4'b0001: begin y_fwd = y_q - W'(STEP); y_back = y_q + W'(STEP); end
      4'b0010: begin y_fwd = y_q + W'(STEP); y_back = y_q - W'(STEP); end
      4'b0100: begin x_fwd = x_q - W'(STEP); x_back = x_q + W'(STEP); end
      4'b1000: begin x_fwd = x_q + W'(STEP); x_back = x_q - W'(STEP); end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    prog_d  = prog_q;
    dir_d   = dir_q;
    // Collision is latched on any edge while moving, frame or not
    pend_d  = pend_q | ((state_q == S_MOVE) & collision);

    if (frame) begin
      unique case (state_q)
        S_CHOOSE: begin
          if (one_hot && fits) begin
            dir_d   = random_direction;
            ox_d    = x_q;
            oy_d    = y_q;
            prog_d  = '0;
            state_d = S_MOVE;
          end
        end
        S_MOVE: begin
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = (x_q == ox_q && y_q == oy_q) ? S_CHOOSE : S_BACKOFF;
          end else begin
            x_d    = x_fwd;
            y_d    = y_fwd;
            prog_d = prog_q + W'(STEP);
            if (prog_q + W'(STEP) == W'(TILE)) begin
              state_d = S_CHOOSE;
              pend_d  = 1'b0;
            end
          end
        end
        S_BACKOFF: begin
          if (x_q == ox_q && y_q == oy_q) begin
            state_d = S_CHOOSE;
          end else begin
            x_d = x_back;
            y_d = y_back;
            if (x_back == ox_q && y_back == oy_q) state_d = S_CHOOSE;
          end
        end
        default: state_d = S_CHOOSE;
      endcase
    end

    moving_d = (state_d != S_CHOOSE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_CHOOSE;
      x_q      <= W'(INIT_X);
      y_q      <= W'(INIT_Y);
      ox_q     <= W'(INIT_X);
      oy_q     <= W'(INIT_Y);
      prog_q   <= '0;
      dir_q    <= '0;
      pend_q   <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      prog_q   <= prog_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      moving_q <= moving_d;
    end
  end

  assign topLeftX  = x_q;
  assign topLeftY  = y_q;
  assign direction = dir_q;
  assign moving    = moving_q;

endmodule

// File: tb/tb_enemy_walker.sv
// Scoreboard bench for enemy_walker: a step-count reference model predicts the
// outputs after every clock; a separate monitor pops and compares them.
module tb_enemy_walker;

  localparam int INIT_X = 64;
  localparam int INIT_Y = 64;
  localparam int TILE   = 32;
  localparam int STEP   = 2;
  localparam int X_MIN  = 32;
  localparam int X_MAX  = 576;
  localparam int Y_MIN  = 32;
  localparam int Y_MAX  = 416;
  localparam int NSTEP  = TILE / STEP;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [3:0]  random_direction = 4'd0;
  logic        collision = 1'b0;
  logic [10:0] topLeftX, topLeftY;
  logic [3:0]  direction;
  logic        moving;

  always #5 clk = ~clk;

  enemy_walker dut (
    .clk(clk), .reset(reset), .enable(enable), .startOfFrame(startOfFrame),
    .random_direction(random_direction), .collision(collision),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .direction(direction), .moving(moving)
  );

  typedef struct { int x; int y; int dir; int mov; } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: walking = 0 idle, 1 forward, 2 retreat; done counts steps taken
  int m_x, m_y, m_dir, m_walk, m_done, m_pend, m_dx, m_dy;

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_x = INIT_X; m_y = INIT_Y; m_dir = 0; m_walk = 0; m_done = 0; m_pend = 0;
    m_dx = 0; m_dy = 0;
  endfunction

  function automatic void model_clock(input bit en, input bit sof, input logic [3:0] rd,
                                      input bit col);
    int old_pend, tx, ty, dx, dy;
    old_pend = m_pend;
    if (m_walk == 1 && col) m_pend = 1;
    if (!(en && sof)) return;
    case (m_walk)
      0: if ($countones(rd) == 1) begin
        dx = int'(rd[3]) - int'(rd[2]);
        dy = int'(rd[1]) - int'(rd[0]);
        tx = m_x + dx * TILE;
        ty = m_y + dy * TILE;
        if (tx >= X_MIN && tx <= X_MAX && ty >= Y_MIN && ty <= Y_MAX) begin
          m_dir = int'(rd); m_dx = dx; m_dy = dy; m_done = 0; m_walk = 1;
        end
      end
      1: if (old_pend != 0) begin
        m_pend = 0;
        m_walk = (m_done == 0) ? 0 : 2;
      end else begin
        m_x += m_dx * STEP; m_y += m_dy * STEP; m_done++;
        if (m_done == NSTEP) begin m_walk = 0; m_pend = 0; end
      end
      default: begin
        m_x -= m_dx * STEP; m_y -= m_dy * STEP; m_done--;
        if (m_done == 0) m_walk = 0;
      end
    endcase
  endfunction

  task automatic cyc(input bit en, input bit sof, input logic [3:0] rd, input bit col);
    exp_t e;
    @(negedge clk);
    enable = en; startOfFrame = sof; random_direction = rd; collision = col;
    @(posedge clk);
    model_clock(en, sof, rd, col);
    e.x = m_x; e.y = m_y; e.dir = m_dir; e.mov = (m_walk != 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic frames(input int n, input logic [3:0] rd);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, rd, 1'b0);
      cyc(1'b1, 1'b1, rd, 1'b0);
    end
  endtask

  // Reset is raised between edges so its asynchronous effect is visible at once
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_x", int'(topLeftX), INIT_X);
    chk("rst_y", int'(topLeftY), INIT_Y);
    chk("rst_dir", int'(direction), 0);
    chk("rst_moving", int'(moving), 0);
    model_reset();
    @(negedge clk);
    enable = 1'b0; startOfFrame = 1'b0; collision = 1'b0;
    reset = 1'b0;
  endtask

  // Monitor: outputs are stable at the falling edge, one prediction per rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("x", int'(topLeftX), e.x);
        chk("y", int'(topLeftY), e.y);
        chk("dir", int'(direction), e.dir);
        chk("moving", int'(moving), e.mov);
      end
    end
  end

  initial begin
    logic [3:0] rd;
    model_reset();
    #1 reset = 1'b1;
    #6;
    chk("init_x", int'(topLeftX), INIT_X);
    chk("init_moving", int'(moving), 0);
    @(negedge clk);
    reset = 1'b0;

    // Full tile to the right
    frames(17, 4'b1000);
    frames(3, 4'b0000);

    // Invalid directions leave the walker idle
    do_reset();
    frames(5, 4'b0000);
    frames(5, 4'b0110);

    // Walk left to the X boundary, then attempt to leave the box
    frames(17, 4'b0100);
    frames(5, 4'b0100);
    frames(5, 4'b0001);

    // Collision after three steps
    do_reset();
    frames(4, 4'b1000);
    cyc(1'b1, 1'b0, 4'b1000, 1'b1);
    frames(5, 4'b0000);

    // Collision before the final step
    do_reset();
    frames(16, 4'b1000);
    cyc(1'b1, 1'b0, 4'b1000, 1'b1);
    frames(17, 4'b0000);

    // Collision before the first step
    do_reset();
    frames(1, 4'b0010);
    cyc(1'b1, 1'b0, 4'b0010, 1'b1);
    frames(3, 4'b0000);

    // Freeze with enable low, then abort with reset mid-move
    do_reset();
    frames(5, 4'b0010);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 4'b0001, 1'b0);
    frames(5, 4'b0010);
    do_reset();
    frames(2, 4'b0000);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 700 == 699) do_reset();
      if ($urandom_range(9) < 7) rd = 4'(4'd1 << $urandom_range(3));
      else rd = 4'($urandom_range(15));
      cyc($urandom_range(7) != 0, $urandom_range(2) == 0, rd, $urandom_range(15) == 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
